// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

  localparam int unsigned APB_ADDR_W  = 32;
  localparam int unsigned APB_DATA_W  = 32;
  localparam int unsigned APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

endpackage

// File: rtl/apb_requester.sv
// APB requester: one command in, SETUP/ACCESS on the bus, one response out.
// A wait-state timeout forces an error completion if the completer never answers.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tmo_q, rsp_tmo_d;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A ready completer wins over a timeout landing on the same edge.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          rsp_tmo_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: directed commands, a scripted completer, a response monitor.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_tmo;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_rsp = 0;
  int          hs_cyc = 0;
  int          acc_cyc = 0;
  // scripted completer configuration for the current transfer
  int          c_wait = 0;
  logic [31:0] c_rdata = 32'h0;
  logic        c_err = 1'b0;
  logic        cur_write = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  logic [31:0] cur_wdata = 32'h0;
  int          acc_n = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Completer: answers after c_wait ACCESS cycles and checks the address phase stays put.
  always @(negedge pclk) begin
    if (psel === 1'b1 && penable === 1'b1) begin
      check("paddr_stable", paddr, cur_addr);
      check("pwrite_stable", 32'(pwrite), 32'(cur_write));
      if (cur_write) check("pwdata_stable", pwdata, cur_wdata);
      pready  = (acc_n == c_wait);
      prdata  = pready ? c_rdata : 32'hBAD0_0BAD;
      pslverr = pready ? c_err : 1'b1;
      acc_n++;
    end else begin
      pready  = 1'b0;
      prdata  = 32'hBAD0_0BAD;
      pslverr = 1'b1;
      acc_n   = 0;
    end
  end

  // Monitor: every response handshake is compared against the oldest expectation.
  always @(negedge pclk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_tmo", 32'(rsp_tmo), 32'(e.tmo));
      end
      hs_cyc = cyc + 1;
      n_rsp++;
    end
  end

  // Present a command, hold it until accepted, then drop cmd_valid at the following negedge.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int wait_n, input logic [31:0] rdata, input logic err,
                      input bit push, input logic [31:0] e_rdata, input logic e_err,
                      input logic e_tmo);
    int n;
    exp_t e;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    check("accept_timeout", 32'(cmd_ready), 32'h1);
    c_wait = wait_n; c_rdata = rdata; c_err = err;
    cur_write = wr; cur_addr = addr; cur_wdata = wdata;
    if (push) begin
      e.rdata = e_rdata; e.err = e_err; e.tmo = e_tmo;
      sb_q.push_back(e);
    end
    acc_cyc = cyc + 1;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (n_rsp < target && n < 300) begin
      @(negedge pclk);
      n++;
    end
    check("rsp_count", 32'(n_rsp), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_psel", 32'(psel), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_pwrite", 32'(pwrite), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err_tmo", 32'({rsp_err, rsp_tmo}), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    rst = 1'b0;

    // 1: zero-wait write, phase timing
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b0, 1'b0);
    check("t1_setup_psel", 32'({psel, penable, cmd_ready, pwrite}), 32'b1001);
    @(negedge pclk);
    check("t1_access", 32'({psel, penable, rsp_valid}), 32'b110);
    @(negedge pclk);
    check("t1_resp", 32'({psel, penable, rsp_valid}), 32'b001);
    wait_rsp(1);

    // 2: read with three wait states
    send(1'b0, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 1'b0, 1, 32'h1234_5678, 1'b0, 1'b0);
    wait_rsp(2);

    // 3: completer never ready -> timeout after 16 ACCESS cycles
    send(1'b0, 32'h0000_0030, 32'h0, 1000, 32'h7777_7777, 1'b0, 1, 32'h0, 1'b1, 1'b1);
    acc = 0; n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge pclk);
      if (penable === 1'b1) acc++;
      n++;
    end
    check("t3_access_cycles", 32'(acc), 32'd16);
    wait_rsp(3);

    // 4: write with slave error, response held back for 5 cycles
    rsp_ready = 1'b0;
    send(1'b1, 32'h0000_0040, 32'h55AA_55AA, 0, 32'hFFFF_FFFF, 1'b1, 1, 32'h0, 1'b1, 1'b0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    repeat (5) begin
      check("t4_hold", {rsp_rdata[27:0], rsp_valid, rsp_err, rsp_tmo, cmd_ready}, 32'b1100);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    wait_rsp(4);

    // 5: reset in the middle of ACCESS abandons the transfer
    send(1'b0, 32'h0000_0050, 32'h0, 1000, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge pclk);
    check("t5_in_access", 32'(penable), 32'h1);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    check("t5_after_rst", 32'({psel, penable, rsp_valid, cmd_ready}), 32'b0001);
    repeat (30) @(negedge pclk);
    check("t5_no_rsp", 32'(n_rsp), 32'd4);

    // 6: ready on the final timeout cycle completes normally
    send(1'b0, 32'h0000_0060, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
    wait_rsp(5);

    // 6b: back-to-back commands, second accepted one cycle after the handshake
    send(1'b1, 32'h0000_0070, 32'h0000_0001, 0, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b0, 1'b0);
    send(1'b0, 32'h0000_0074, 32'h0, 2, 32'hA5A5_0001, 1'b0, 1, 32'hA5A5_0001, 1'b0, 1'b0);
    check("t6_gap", 32'(acc_cyc - hs_cyc), 32'd1);
    wait_rsp(7);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    repeat (3) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
